// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmit path: FSM encoding and default word width.
package serial_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } ser_state_t;

endpackage

// File: rtl/piso_ser_tx_if.sv
// Parallel word handshake into the serial transmitter (valid/ready).
interface piso_ser_tx_if
  import serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/ser_hold_buf.sv
// One-word holding buffer in front of the shifter; owns the input handshake.
module ser_hold_buf
  import serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  piso_ser_tx_if.slave     in_if,
  output logic [WIDTH-1:0] hold_data,
  output logic             hold_valid
);

  logic accept;

  // A draining buffer can take a new word on the same edge it empties.
  assign in_if.in_ready = !rst && (!hold_valid || load);
  assign accept         = in_if.in_valid && in_if.in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_data  <= '0;
      hold_valid <= 1'b0;
    end else if (accept) begin
      hold_data  <= in_if.in_data;
      hold_valid <= 1'b1;
    end else if (load) begin
      hold_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/piso_ser_tx.sv
// Parallel-in serial-out transmitter: MSB first, one bit per clock, optional idle gap between words.
//   state    | meaning
//   ST_IDLE  | nothing shifting; loads as soon as the holding buffer has a word
//   ST_SHIFT | sdo carries shreg MSB; bit_cnt counts bits of the current word
//   ST_GAP   | sdo idle for GAP_CYCLES cycles after every word
module piso_ser_tx
  import serial_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int GAP_CYCLES = 0
) (
  input  logic         clk,
  input  logic         rst,
  piso_ser_tx_if.slave in_if,
  output logic         sdo,
  output logic         sdo_valid,
  output logic         sof,
  output logic         busy
);

  localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam bit            HAS_GAP  = (GAP_CYCLES > 0);
  localparam logic [3:0]    GAP_LAST = HAS_GAP ? 4'(GAP_CYCLES - 1) : 4'd0;

  ser_state_t       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [3:0]       gap_cnt_q, gap_cnt_d;
  logic [WIDTH-1:0] hold_data;
  logic             hold_valid;
  logic             load;
  logic             last_bit;
  logic             last_gap;

  ser_hold_buf #(.WIDTH(WIDTH)) u_hold (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .in_if      (in_if),
    .hold_data  (hold_data),
    .hold_valid (hold_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    last_bit  = (bit_cnt_q == LAST_BIT);
    last_gap  = (gap_cnt_q == GAP_LAST);
    load      = 1'b0;

    case (state_q)
      ST_IDLE:  load = hold_valid;
      ST_SHIFT: load = hold_valid && last_bit && !HAS_GAP;
      ST_GAP:   load = hold_valid && last_gap;
      default:  load = 1'b0;
    endcase

    if (load) begin
      shreg_d   = hold_data;
      bit_cnt_d = '0;
      state_d   = ST_SHIFT;
    end else begin
      case (state_q)
        ST_SHIFT: begin
          shreg_d   = shreg_q << 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (last_bit) begin
            if (HAS_GAP) begin
              state_d   = ST_GAP;
              gap_cnt_d = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_GAP: begin
          gap_cnt_d = gap_cnt_q + 4'd1;
          if (last_gap) state_d = ST_IDLE;
        end
        default: ;
      endcase
    end
  end

  assign sdo_valid = (state_q == ST_SHIFT);
  assign sdo       = sdo_valid && shreg_q[WIDTH-1];
  assign sof       = sdo_valid && (bit_cnt_q == '0);
  assign busy      = hold_valid || (state_q != ST_IDLE);

endmodule

// File: tb/tb_piso_ser_tx.sv
// Directed bench for piso_ser_tx: three configurations (4b/gap0, 4b/gap2, 8b/gap0).
module tb_piso_ser_tx;
  import serial_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  piso_ser_tx_if #(.WIDTH(4)) if_g0 ();
  piso_ser_tx_if #(.WIDTH(4)) if_g2 ();
  piso_ser_tx_if #(.WIDTH(8)) if_w8 ();

  logic sdo_g0, v_g0, sof_g0, busy_g0;
  logic sdo_g2, v_g2, sof_g2, busy_g2;
  logic sdo_w8, v_w8, sof_w8, busy_w8;

  piso_ser_tx #(.WIDTH(4), .GAP_CYCLES(0)) u_g0 (
    .clk(clk), .rst(rst), .in_if(if_g0),
    .sdo(sdo_g0), .sdo_valid(v_g0), .sof(sof_g0), .busy(busy_g0)
  );
  piso_ser_tx #(.WIDTH(4), .GAP_CYCLES(2)) u_g2 (
    .clk(clk), .rst(rst), .in_if(if_g2),
    .sdo(sdo_g2), .sdo_valid(v_g2), .sof(sof_g2), .busy(busy_g2)
  );
  piso_ser_tx #(.WIDTH(8), .GAP_CYCLES(0)) u_w8 (
    .clk(clk), .rst(rst), .in_if(if_w8),
    .sdo(sdo_w8), .sdo_valid(v_w8), .sof(sof_w8), .busy(busy_w8)
  );

  // Downstream 4-bit left-shift receiver with its active-low reset
  logic       rx_rst_b;
  logic [3:0] rx4;
  assign rx_rst_b = ~rst;
  always @(posedge clk or negedge rx_rst_b) begin
    if (!rx_rst_b)  rx4 <= 4'd0;
    else if (v_g0)  rx4 <= {rx4[2:0], sdo_g0};
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [11:0] exp_v, exp_bits, exp_sof, exp_rdy;
  logic [15:0] w_bits, w_sof;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    if_g0.in_data = '0; if_g0.in_valid = 1'b0;
    if_g2.in_data = '0; if_g2.in_valid = 1'b0;
    if_w8.in_data = '0; if_w8.in_valid = 1'b0;

    // reset state
    #12;
    chk("rst_outs", 8'({if_g0.in_ready, v_g0, sdo_g0, sof_g0, busy_g0}), 8'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_release_ready", 8'(if_g0.in_ready), 8'd1);
    chk("rst_release_busy", 8'(busy_g0), 8'd0);

    // T1: single word 1011
    if_g0.in_data = 4'b1011; if_g0.in_valid = 1'b1;
    @(negedge clk);
    if_g0.in_valid = 1'b0;
    #1;
    chk("t1_held_busy", 8'({busy_g0, v_g0}), 8'b10);
    exp_bits = 12'hB00; exp_sof = 12'h800;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk($sformatf("t1_bit%0d", i), 8'({v_g0, sdo_g0, sof_g0}), 8'({1'b1, exp_bits[11], exp_sof[11]}));
      exp_bits = exp_bits << 1; exp_sof = exp_sof << 1;
    end
    @(negedge clk); #1;
    chk("t1_idle", 8'({v_g0, busy_g0}), 8'd0);
    chk("t1_rx", 8'(rx4), 8'hB);

    // T2: back-to-back A,5,F with valid held
    if_g0.in_data = 4'hA; if_g0.in_valid = 1'b1;
    #1 chk("t2_rdy_a", 8'(if_g0.in_ready), 8'd1);
    @(negedge clk);
    if_g0.in_data = 4'h5;
    #1 chk("t2_rdy_5", 8'(if_g0.in_ready), 8'd1);
    exp_v = 12'hFFF; exp_bits = 12'hA5F; exp_sof = 12'h888; exp_rdy = 12'h11F;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 0) if_g0.in_data = 4'hF;
      if (i == 4) if_g0.in_valid = 1'b0;
      #1;
      chk($sformatf("t2_bit%0d", i), 8'({v_g0, sdo_g0, sof_g0}), 8'({exp_v[11], exp_bits[11], exp_sof[11]}));
      chk($sformatf("t2_rdy%0d", i), 8'(if_g0.in_ready), 8'(exp_rdy[11]));
      exp_v = exp_v << 1; exp_bits = exp_bits << 1; exp_sof = exp_sof << 1; exp_rdy = exp_rdy << 1;
    end
    @(negedge clk); #1;
    chk("t2_idle", 8'({v_g0, busy_g0}), 8'd0);

    // T3: GAP_CYCLES=2, words C then 3
    if_g2.in_data = 4'hC; if_g2.in_valid = 1'b1;
    @(negedge clk);
    if_g2.in_data = 4'h3;
    exp_v = 12'hF3C; exp_bits = 12'hC0C; exp_sof = 12'h820;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 0) if_g2.in_valid = 1'b0;
      #1;
      chk($sformatf("t3_bit%0d", i), 8'({v_g2, sdo_g2, sof_g2}), 8'({exp_v[11], exp_bits[11], exp_sof[11]}));
      if (i == 11) chk("t3_trailing_gap_busy", 8'(busy_g2), 8'd1);
      exp_v = exp_v << 1; exp_bits = exp_bits << 1; exp_sof = exp_sof << 1;
    end
    @(negedge clk); #1;
    chk("t3_idle", 8'({v_g2, busy_g2}), 8'd0);

    // T4: backpressure, 9 presented while hold is full and shifter mid-word
    @(negedge clk);
    if_g0.in_data = 4'h7; if_g0.in_valid = 1'b1;
    @(negedge clk);
    if_g0.in_data = 4'h2;
    exp_v = 12'hFFF; exp_bits = 12'h729; exp_sof = 12'h888; exp_rdy = 12'h11F;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 0) if_g0.in_data = 4'h9;
      if (i == 4) if_g0.in_valid = 1'b0;
      #1;
      chk($sformatf("t4_bit%0d", i), 8'({v_g0, sdo_g0, sof_g0}), 8'({exp_v[11], exp_bits[11], exp_sof[11]}));
      chk($sformatf("t4_rdy%0d", i), 8'(if_g0.in_ready), 8'(exp_rdy[11]));
      exp_v = exp_v << 1; exp_bits = exp_bits << 1; exp_sof = exp_sof << 1; exp_rdy = exp_rdy << 1;
    end
    @(negedge clk); #1;
    chk("t4_once_idle", 8'({v_g0, busy_g0}), 8'd0);

    // T5: async reset after two bits of E
    @(negedge clk);
    if_g0.in_data = 4'hE; if_g0.in_valid = 1'b1;
    @(negedge clk);
    if_g0.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    chk("t5_pre_bit1", 8'({v_g0, sdo_g0, sof_g0, busy_g0}), 8'b1101);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_drop", 8'({if_g0.in_ready, v_g0, sdo_g0, sof_g0, busy_g0}), 8'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t5_release", 8'({if_g0.in_ready, busy_g0, v_g0}), 8'b100);
    if_g0.in_data = 4'h6; if_g0.in_valid = 1'b1;
    @(negedge clk);
    if_g0.in_valid = 1'b0;
    exp_bits = 12'h600; exp_sof = 12'h800;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk($sformatf("t5_bit%0d", i), 8'({v_g0, sdo_g0, sof_g0}), 8'({1'b1, exp_bits[11], exp_sof[11]}));
      exp_bits = exp_bits << 1; exp_sof = exp_sof << 1;
    end
    @(negedge clk); #1;
    chk("t5_idle", 8'({v_g0, busy_g0}), 8'd0);
    chk("t5_rx", 8'(rx4), 8'h6);

    // T6: WIDTH=8, 81 followed immediately by 3C
    if_w8.in_data = 8'h81; if_w8.in_valid = 1'b1;
    @(negedge clk);
    if_w8.in_data = 8'h3C;
    w_bits = 16'h813C; w_sof = 16'h8080;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i == 0) if_w8.in_valid = 1'b0;
      #1;
      chk($sformatf("t6_bit%0d", i), 8'({v_w8, sdo_w8, sof_w8}), 8'({1'b1, w_bits[15], w_sof[15]}));
      w_bits = w_bits << 1; w_sof = w_sof << 1;
    end
    @(negedge clk); #1;
    chk("t6_idle", 8'({v_w8, busy_w8}), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
